// File: rtl/ad_seq.sv
// ADC0809 conversion sequencer: drives address/ALE/START/OE with clock-counted
// pulse widths, waits on a synchronized EOC, latches the result and raises sticky flags.
module ad_seq #(
  parameter int ALE_W   = 2,
  parameter int START_W = 2,
  parameter int OE_W    = 2,
  parameter int TO_CYC  = 4095
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       GO,
  input  logic [2:0] CH,
  input  logic       ACK,
  input  logic       EOC,
  input  logic [7:0] DIN,
  output logic [2:0] ADDR,
  output logic       ALE,
  output logic       START,
  output logic       OE,
  output logic [7:0] DOUT,
  output logic       BUSY,
  output logic       DONE,
  output logic       TIMEOUT,
  output logic       IRQ2
);

  typedef enum logic [2:0] {IDLE, SETUP, ALEP, STARTP, WLOW, WHIGH, READ} state_t;

  localparam logic [15:0] ALE_LAST   = 16'(ALE_W - 1);
  localparam logic [15:0] START_LAST = 16'(START_W - 1);
  localparam logic [15:0] OE_LAST    = 16'(OE_W - 1);
  localparam logic [15:0] TO_LAST    = 16'(TO_CYC - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] tcnt;
  logic        eoc_p0, eoc_p1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      tcnt    <= '0;
      eoc_p0  <= 1'b0;
      eoc_p1  <= 1'b0;
      ADDR    <= '0;
      ALE     <= 1'b0;
      START   <= 1'b0;
      OE      <= 1'b0;
      DOUT    <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      TIMEOUT <= 1'b0;
      IRQ2    <= 1'b0;
    end else begin
      // EOC is asynchronous to CLK; only eoc_p1 feeds the state machine
      eoc_p0 <= EOC;
      eoc_p1 <= eoc_p0;

      // A set later in this block overrides the ACK clear on the same edge
      if (ACK) IRQ2 <= 1'b0;

      case (state)
        IDLE: begin
          if (GO) begin
            ADDR    <= CH;
            DONE    <= 1'b0;
            TIMEOUT <= 1'b0;
            BUSY    <= 1'b1;
            cnt     <= '0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          ALE   <= 1'b1;
          cnt   <= '0;
          state <= ALEP;
        end
        ALEP: begin
          if (cnt == ALE_LAST) begin
            ALE   <= 1'b0;
            START <= 1'b1;
            cnt   <= '0;
            state <= STARTP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STARTP: begin
          if (cnt == START_LAST) begin
            START <= 1'b0;
            tcnt  <= '0;
            state <= WLOW;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WLOW, WHIGH: begin
          // Timeout takes priority over an EOC edge seen on the same clock
          if (tcnt == TO_LAST) begin
            TIMEOUT <= 1'b1;
            IRQ2    <= 1'b1;
            BUSY    <= 1'b0;
            state   <= IDLE;
          end else begin
            tcnt <= tcnt + 16'd1;
            if (state == WLOW && !eoc_p1) begin
              state <= WHIGH;
            end else if (state == WHIGH && eoc_p1) begin
              OE    <= 1'b1;
              cnt   <= '0;
              state <= READ;
            end
          end
        end
        READ: begin
          if (cnt == OE_LAST) begin
            OE    <= 1'b0;
            DOUT  <= DIN;
            DONE  <= 1'b1;
            IRQ2  <= 1'b1;
            BUSY  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          ALE   <= 1'b0;
          START <= 1'b0;
          OE    <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ad_seq.sv
// Bench for ad_seq: directed stimulus pushes expected results into a scoreboard
// queue; a monitor pops and compares each time a conversion ends (BUSY falls).
module tb_ad_seq;

  localparam int OE_W = 2;
  localparam int TO2  = 16;

  logic       clk = 1'b0;
  logic       rst, go, go2, ack, eoc, eoc2;
  logic [2:0] ch;
  logic [7:0] din;

  logic [2:0] addr_v  [2];
  logic       ale_v   [2];
  logic       start_v [2];
  logic       oe_v    [2];
  logic [7:0] dout_v  [2];
  logic       busy_v  [2];
  logic       done_v  [2];
  logic       to_v    [2];
  logic       irq_v   [2];

  always #5 clk = ~clk;

  ad_seq u_dut (
    .CLK(clk), .RST(rst), .GO(go), .CH(ch), .ACK(ack), .EOC(eoc), .DIN(din),
    .ADDR(addr_v[0]), .ALE(ale_v[0]), .START(start_v[0]), .OE(oe_v[0]),
    .DOUT(dout_v[0]), .BUSY(busy_v[0]), .DONE(done_v[0]), .TIMEOUT(to_v[0]),
    .IRQ2(irq_v[0])
  );

  ad_seq #(.TO_CYC(TO2)) u_dut_to (
    .CLK(clk), .RST(rst), .GO(go2), .CH(ch), .ACK(ack), .EOC(eoc2), .DIN(din),
    .ADDR(addr_v[1]), .ALE(ale_v[1]), .START(start_v[1]), .OE(oe_v[1]),
    .DOUT(dout_v[1]), .BUSY(busy_v[1]), .DONE(done_v[1]), .TIMEOUT(to_v[1]),
    .IRQ2(irq_v[1])
  );

  typedef struct {
    int         dut;
    logic [7:0] dout;
    logic       done;
    logic       to;
    logic       irq;
    int         lat;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   overlap = 0;
  int   sfall [2];
  logic bprev [2];
  logic sprev [2];
  int   ale_run = 0, ale_len = 0, ale_pulses = 0;
  int   st_run = 0, st_len = 0;
  int   oe_run = 0, oe_len = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic sig(input int s);
    case (s)
      0: return start_v[0];
      1: return oe_v[0];
      2: return busy_v[0];
      3: return start_v[1];
      4: return busy_v[1];
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int s, input logic val, input int maxc, input string name);
    int n = 0;
    while (sig(s) !== val && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(name, sig(s), val);
  endtask

  // Monitor: samples just after each rising edge
  initial begin
    bprev = '{1'b0, 1'b0};
    sprev = '{1'b0, 1'b0};
    sfall = '{0, 0};
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          bprev[k] = 1'b0;
          sprev[k] = 1'b0;
        end else begin
          if (sprev[k] && !start_v[k]) sfall[k] = cyc;
          if (bprev[k] && !busy_v[k]) begin
            if (sbq.size() == 0) begin
              chk("sb_pending", 0, 1);
            end else begin
              exp_t e;
              e = sbq.pop_front();
              chk("sb_dut", k, e.dut);
              chk("sb_dout", dout_v[k], e.dout);
              chk("sb_done", done_v[k], e.done);
              chk("sb_timeout", to_v[k], e.to);
              chk("sb_irq2", irq_v[k], e.irq);
              if (e.lat >= 0) chk("sb_latency", cyc - sfall[k], e.lat);
            end
          end
          if (int'(ale_v[k]) + int'(start_v[k]) + int'(oe_v[k]) > 1) overlap++;
          bprev[k] = busy_v[k];
          sprev[k] = start_v[k];
        end
      end
      if (ale_v[0]) ale_run++;
      else if (ale_run > 0) begin ale_len = ale_run; ale_run = 0; ale_pulses++; end
      if (start_v[0]) st_run++;
      else if (st_run > 0) begin st_len = st_run; st_run = 0; end
      if (oe_v[0]) oe_run++;
      else if (oe_run > 0) begin oe_len = oe_run; oe_run = 0; end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Stimulus: driven on falling edges
  initial begin
    int n;
    rst = 1'b1; go = 1'b0; go2 = 1'b0; ack = 1'b0; eoc = 1'b1; eoc2 = 1'b1;
    ch = '0; din = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state and idle
    chk("rst_addr", addr_v[0], 0);
    chk("rst_ale_start_oe", {ale_v[0], start_v[0], oe_v[0]}, 0);
    chk("rst_dout", dout_v[0], 0);
    chk("rst_flags", {busy_v[0], done_v[0], to_v[0], irq_v[0]}, 0);
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy_v[0] || busy_v[1]) n++;
    end
    chk("idle_busy_cycles", n, 0);

    // Nominal conversion, CH=5, DIN=A7; EOC rises 23 clocks after START falls
    ale_pulses = 0;
    ch = 3'd5; din = 8'hA7;
    sbq.push_back('{dut: 0, dout: 8'hA7, done: 1'b1, to: 1'b0, irq: 1'b1, lat: 23 + 3 + OE_W});
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    chk("nom_busy_edge0", busy_v[0], 1);
    chk("nom_addr_edge0", addr_v[0], 5);
    chk("nom_ale_setup", ale_v[0], 0);
    @(negedge clk);
    chk("nom_ale_rise", ale_v[0], 1);
    wait_for(0, 1'b1, 20, "nom_start_rise");
    wait_for(0, 1'b0, 20, "nom_start_fall");
    repeat (3) @(negedge clk);
    eoc = 1'b0;
    repeat (10) @(negedge clk);
    // Second GO while waiting in WHIGH must be ignored
    ch = 3'd2; go = 1'b1;
    @(negedge clk);
    go = 1'b0; ch = 3'd0;
    repeat (9) @(negedge clk);
    eoc = 1'b1;
    wait_for(1, 1'b1, 20, "nom_oe_rise");
    repeat (OE_W - 1) @(negedge clk);
    ack = 1'b1;                       // lands on the DONE-set edge
    @(negedge clk);
    ack = 1'b0;
    chk("nom_busy_end", busy_v[0], 0);
    chk("nom_irq2_collision", irq_v[0], 1);
    chk("nom_addr_held", addr_v[0], 5);
    chk("nom_ale_pulses", ale_pulses, 1);
    chk("nom_ale_width", ale_len, 2);
    chk("nom_start_width", st_len, 2);
    chk("nom_oe_width", oe_len, OE_W);

    // Lone ACK clears IRQ2 only
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("ack_irq2_clear", irq_v[0], 0);
    chk("ack_done_kept", done_v[0], 1);

    // Timeout instance: one good conversion (A7), then EOC stuck high
    sbq.push_back('{dut: 1, dout: 8'hA7, done: 1'b1, to: 1'b0, irq: 1'b1, lat: -1});
    go2 = 1'b1;
    @(negedge clk);
    go2 = 1'b0;
    wait_for(3, 1'b1, 20, "b_start_rise");
    wait_for(3, 1'b0, 20, "b_start_fall");
    eoc2 = 1'b0;
    repeat (3) @(negedge clk);
    eoc2 = 1'b1;
    wait_for(4, 1'b0, 30, "b_conv_end");
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("b_irq2_cleared", irq_v[1], 0);
    din = 8'h3C;
    sbq.push_back('{dut: 1, dout: 8'hA7, done: 1'b0, to: 1'b1, irq: 1'b1, lat: TO2});
    go2 = 1'b1;
    @(negedge clk);
    go2 = 1'b0;
    wait_for(3, 1'b1, 20, "to_start_rise");
    wait_for(3, 1'b0, 20, "to_start_fall");
    chk("to_done_cleared", done_v[1], 0);
    wait_for(4, 1'b0, 40, "to_busy_fall");
    chk("to_timeout", to_v[1], 1);
    chk("to_dout_kept", dout_v[1], 8'hA7);

    // Reset while START is high
    ch = 3'd3; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_for(0, 1'b1, 10, "rm_start_rise");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rm_start", start_v[0], 0);
    chk("rm_busy", busy_v[0], 0);
    chk("rm_flags", {done_v[0], to_v[0], irq_v[0]}, 0);
    chk("rm_dout_addr", {dout_v[0], addr_v[0]}, 0);

    // Complete conversion after reset; EOC rises 5 clocks after START falls
    ch = 3'd6; din = 8'h5E;
    sbq.push_back('{dut: 0, dout: 8'h5E, done: 1'b1, to: 1'b0, irq: 1'b1, lat: 5 + 3 + OE_W});
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    chk("post_addr", addr_v[0], 6);
    wait_for(0, 1'b1, 20, "post_start_rise");
    wait_for(0, 1'b0, 20, "post_start_fall");
    @(negedge clk);
    eoc = 1'b0;
    repeat (4) @(negedge clk);
    eoc = 1'b1;
    wait_for(2, 1'b0, 20, "post_busy_fall");
    chk("post_dout", dout_v[0], 8'h5E);

    repeat (5) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    chk("pulse_overlap", overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
